// File: rtl/tmds_pkg.sv
// Shared TMDS constants and helpers for the channel encoder and its transition minimiser.
package tmds_pkg;

  localparam int unsigned TmdsDispWidthDefault = 5;

  localparam logic [9:0] TmdsCtrl00 = 10'b1101010100;
  localparam logic [9:0] TmdsCtrl01 = 10'b0010101011;
  localparam logic [9:0] TmdsCtrl10 = 10'b0101010100;
  localparam logic [9:0] TmdsCtrl11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_transition_minimizer.sv
// TMDS stage 1: XOR/XNOR chain that minimises transitions; qm[8] = 1 marks the XOR form.
module tmds_transition_minimizer
  import tmds_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [8:0] qm_o
);

  logic [3:0] n1d;
  logic       use_xnor;

  // Chain built in a function so each bit depends only on a local variable.
  function automatic logic [8:0] minimize(input logic [7:0] d, input logic xnor_sel);
    logic [8:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = xnor_sel ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~xnor_sel;
    return q;
  endfunction

  always_comb begin
    n1d      = popcount8(data_i);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_i[0]);
    qm_o     = minimize(data_i, use_xnor);
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// Single-channel TMDS 8b/10b encoder with running DC-disparity tracking.
// Define TMDS_PIPELINE_EN to register qm between the two stages (2-cycle latency).
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int unsigned DISPARITY_WIDTH = TmdsDispWidthDefault
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       data_enable,
  input  logic [7:0] data,
  input  logic [1:0] control,
  output logic [9:0] symbol
);

  localparam int unsigned W = DISPARITY_WIDTH;
  localparam logic signed [W-1:0] Zero     = '0;
  localparam logic signed [W-1:0] Two      = W'(2);
  localparam logic signed [W-1:0] Eight    = W'(8);
  localparam logic signed [W-1:0] NegEight = -Eight;

  logic [8:0] qm_s1;

  tmds_transition_minimizer u_minimizer (
    .data_i (data),
    .qm_o   (qm_s1)
  );

  logic [8:0] qm;
  logic       de;
  logic [1:0] ctrl;

`ifdef TMDS_PIPELINE_EN
  logic [8:0] qm_q;
  logic       de_q;
  logic [1:0] ctrl_q;

  // Reset parks the intermediate stage on a control-00 period.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      qm_q   <= '0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= qm_s1;
      de_q   <= data_enable;
      ctrl_q <= control;
    end
  end

  assign qm   = qm_q;
  assign de   = de_q;
  assign ctrl = ctrl_q;
`else
  assign qm   = qm_s1;
  assign de   = data_enable;
  assign ctrl = control;
`endif

  logic [9:0]          symbol_d, symbol_q;
  logic signed [W-1:0] cnt_d, cnt_q;
  logic [3:0]          n1;
  logic signed [W-1:0] n1_s;
  logic signed [W-1:0] bal;

  always_comb begin
    symbol_d = TmdsCtrl00;
    cnt_d    = Zero;
    n1       = popcount8(qm[7:0]);
    n1_s     = signed'({{(W-4){1'b0}}, n1});
    bal      = (n1_s <<< 1) - Eight;  // n1 - n0
    if (!de) begin
      unique case (ctrl)
        2'b00: symbol_d = TmdsCtrl00;
        2'b01: symbol_d = TmdsCtrl01;
        2'b10: symbol_d = TmdsCtrl10;
        2'b11: symbol_d = TmdsCtrl11;
      endcase
    end else if ((cnt_q == Zero) || (n1 == 4'd4)) begin
      symbol_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_d    = qm[8] ? (cnt_q + bal) : (cnt_q - bal);
    end else if (((cnt_q > Zero) && (n1 > 4'd4)) || ((cnt_q < Zero) && (n1 < 4'd4))) begin
      symbol_d = {1'b1, qm[8], ~qm[7:0]};
      cnt_d    = qm[8] ? (cnt_q + Two - bal) : (cnt_q - bal);
    end else begin
      symbol_d = {1'b0, qm[8], qm[7:0]};
      cnt_d    = qm[8] ? (cnt_q + bal) : (cnt_q - Two + bal);
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      symbol_q <= TmdsCtrl00;
      cnt_q    <= Zero;
    end else begin
      symbol_q <= symbol_d;
      cnt_q    <= cnt_d;
    end
  end

  assign symbol = symbol_q;

  // Disparity must stay within -8..+8; anything else is an encoder bug.
  a_cnt_range: assert property (@(posedge pixel_clock) disable iff (reset)
    (cnt_q >= NegEight) && (cnt_q <= Eight));

endmodule
